router_input_mc: RTL and testbench

// Multi-channel input-activation router between the GLB and NUM_CH PE scratchpads. On a start pulse it

---
 rtl/router_input_mc.sv | 192 +++++++++++++++++++
 tb/tb_router_input_mc.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_input_mc.sv
// Multi-channel input-activation router: streams a GLB address window through a credit-tracked
// staging FIFO to NUM_CH spad channels, either broadcast to all or round-robin one word per channel.
module router_input_mc #(
  parameter int unsigned DATA_BITWIDTH     = 16,
  parameter int unsigned ADDR_BITWIDTH_GLB = 10,
  parameter int unsigned NUM_CH            = 4,
  parameter int unsigned FIFO_DEPTH        = 8,
  parameter int unsigned CNT_BITWIDTH      = 10
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic                              mode,
  input  logic [ADDR_BITWIDTH_GLB-1:0]      base_addr,
  input  logic [CNT_BITWIDTH-1:0]           num_words,
  output logic [ADDR_BITWIDTH_GLB-1:0]      val_addr_read,
  output logic                              val_req_read,
  input  logic [DATA_BITWIDTH-1:0]          val_data_i,
  input  logic                              val_enable_i,
  output logic [NUM_CH*DATA_BITWIDTH-1:0]   val_data_o,
  output logic [NUM_CH-1:0]                 val_enable_o,
  input  logic [NUM_CH-1:0]                 val_ready_i,
  output logic                              busy,
  output logic                              done
);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SUM_W = PTR_W + 2;
  localparam int unsigned RR_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t                         state;
  logic                           mode_r;
  logic [ADDR_BITWIDTH_GLB-1:0]   base_r;
  logic [CNT_BITWIDTH-1:0]        num_r;
  logic [CNT_BITWIDTH-1:0]        req_cnt;
  logic [CNT_BITWIDTH-1:0]        del_cnt;
  logic [CNT_BITWIDTH-1:0]        del_next;
  logic [CNT_W-1:0]               outstanding;
  logic [CNT_W-1:0]               outstanding_next;
  logic [CNT_W-1:0]               fcount;
  logic [CNT_W-1:0]               fcount_next;
  logic [PTR_W-1:0]               wr_ptr;
  logic [PTR_W-1:0]               rd_ptr;
  logic [PTR_W-1:0]               rd_ptr_next;
  logic [DATA_BITWIDTH-1:0]       mem [FIFO_DEPTH];
  logic [DATA_BITWIDTH-1:0]       head_next;
  logic [NUM_CH-1:0]              served;
  logic [NUM_CH-1:0]              served_next;
  logic [NUM_CH-1:0]              enable_next;
  logic [RR_W-1:0]                rr;
  logic [RR_W-1:0]                rr_next;
  logic                           push;
  logic                           pop;
  logic                           fire;

  // Next-cycle datapath: the strobes and head word are precomputed so every output is a flop.
  always_comb begin
    fire             = 1'b0;
    pop              = 1'b0;
    push             = 1'b0;
    fcount_next      = fcount;
    outstanding_next = outstanding;
    rd_ptr_next      = rd_ptr;
    head_next        = '0;
    served_next      = served;
    rr_next          = rr;
    del_next         = del_cnt;
    enable_next      = '0;

    // Credit covers both words already staged and words still in flight from the GLB.
    fire = (state == FETCH) && (req_cnt != num_r) &&
           ((SUM_W'(fcount) + SUM_W'(outstanding)) < SUM_W'(FIFO_DEPTH));

    if (mode_r) pop = (fcount != '0) && val_ready_i[rr];
    else        pop = (fcount != '0) && (&(served | (val_enable_o & val_ready_i)));

    push = val_enable_i && ((fcount != CNT_W'(FIFO_DEPTH)) || pop);

    if (push && !pop)      fcount_next = fcount + CNT_W'(1);
    else if (!push && pop) fcount_next = fcount - CNT_W'(1);

    if (fire && !val_enable_i)      outstanding_next = outstanding + CNT_W'(1);
    else if (!fire && val_enable_i) outstanding_next = outstanding - CNT_W'(1);

    if (pop) begin
      rd_ptr_next = rd_ptr + PTR_W'(1);
      del_next    = del_cnt + CNT_BITWIDTH'(1);
    end

    // A word pushed into a FIFO that is empty after this cycle's pop becomes the new head.
    head_next = (push && (wr_ptr == rd_ptr_next)) ? val_data_i : mem[rd_ptr_next];

    if (pop || state == IDLE) served_next = '0;
    else                      served_next = served | (val_enable_o & val_ready_i);

    if (state == IDLE)    rr_next = '0;
    else if (pop && mode_r) rr_next = (rr == RR_W'(NUM_CH - 1)) ? '0 : rr + RR_W'(1);

    if (fcount_next != '0) begin
      if (mode_r) enable_next = NUM_CH'(1) << rr_next;
      else        enable_next = ~served_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= val_data_i;
  end

  // Control FSM, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      mode_r        <= 1'b0;
      base_r        <= '0;
      num_r         <= '0;
      req_cnt       <= '0;
      del_cnt       <= '0;
      outstanding   <= '0;
      fcount        <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      served        <= '0;
      rr            <= '0;
      val_addr_read <= '0;
      val_req_read  <= 1'b0;
      val_data_o    <= '0;
      val_enable_o  <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      fcount       <= fcount_next;
      outstanding  <= outstanding_next;
      rd_ptr       <= rd_ptr_next;
      served       <= served_next;
      rr           <= rr_next;
      del_cnt      <= del_next;
      val_enable_o <= enable_next;
      val_data_o   <= {NUM_CH{head_next}};
      val_req_read <= fire;
      done         <= 1'b0;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (fire) begin
        val_addr_read <= base_r + ADDR_BITWIDTH_GLB'(req_cnt);
        req_cnt       <= req_cnt + CNT_BITWIDTH'(1);
      end

      case (state)
        IDLE: begin
          if (start) begin
            mode_r  <= mode;
            base_r  <= base_addr;
            num_r   <= num_words;
            req_cnt <= '0;
            del_cnt <= '0;
            if (num_words == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= FETCH;
              busy  <= 1'b1;
            end
          end
        end
        FETCH: begin
          if (req_cnt == num_r) begin
            if (del_next == num_r) begin
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (del_next == num_r) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_router_input_mc.sv
// Randomized bench for router_input_mc: a GLB responder with configurable latency, per-channel
// sinks with ready patterns, and a model deriving each channel's word stream from the address window.
module tb_router_input_mc;
  localparam int unsigned DW    = 16;
  localparam int unsigned AW    = 10;
  localparam int unsigned NCH   = 4;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = 10;
  localparam int unsigned MAXW  = 64;

  logic                clk = 1'b0;
  logic                reset;
  logic                start;
  logic                mode;
  logic [AW-1:0]       base_addr;
  logic [CW-1:0]       num_words;
  logic [AW-1:0]       val_addr_read;
  logic                val_req_read;
  logic [DW-1:0]       val_data_i;
  logic                val_enable_i;
  logic [NCH*DW-1:0]   val_data_o;
  logic [NCH-1:0]      val_enable_o;
  logic [NCH-1:0]      val_ready_i;
  logic                busy;
  logic                done;

  always #5 clk = ~clk;

  router_input_mc #(
    .DATA_BITWIDTH(DW), .ADDR_BITWIDTH_GLB(AW), .NUM_CH(NCH),
    .FIFO_DEPTH(DEPTH), .CNT_BITWIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .base_addr(base_addr), .num_words(num_words),
    .val_addr_read(val_addr_read), .val_req_read(val_req_read),
    .val_data_i(val_data_i), .val_enable_i(val_enable_i),
    .val_data_o(val_data_o), .val_enable_o(val_enable_o), .val_ready_i(val_ready_i),
    .busy(busy), .done(done)
  );

  typedef struct { logic [AW-1:0] addr; int due; } rsp_t;
  rsp_t          pend [$];
  logic [DW-1:0] glb_mem [1<<AW];
  logic [AW-1:0] addr_log [$];
  logic [DW-1:0] rx [NCH][MAXW];
  int            rx_n [NCH];
  logic [DW-1:0] exp_rx [NCH][MAXW];
  int            exp_n [NCH];
  logic [AW-1:0] exp_addr [MAXW];
  int            done_err, busy_err, credit_err, timeout_err, req_window, first_rsp, first_en;
  int            vectors = 0;
  int            miscompares = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: word i comes from base+i (mod GLB size); broadcast copies it to every channel,
  // round-robin hands it to channel i mod NCH.
  task automatic build_model(input logic m, input logic [AW-1:0] b, input logic [CW-1:0] n);
    logic [AW-1:0] a;
    for (int c = 0; c < NCH; c++) exp_n[c] = 0;
    for (int i = 0; i < int'(n); i++) begin
      a = AW'(int'(b) + i);
      exp_addr[i] = a;
      for (int c = 0; c < NCH; c++) begin
        if (!m || (i % NCH) == c) begin
          exp_rx[c][exp_n[c]] = glb_mem[a];
          exp_n[c]++;
        end
      end
    end
  endtask

  // Drives one transfer to completion; rdy_mode 0=all ready, 1=random, 2=ch2 stalled 20 cycles,
  // 3=all stalled 25 cycles. inject>0 pulses a conflicting start at that cycle.
  task automatic run_xfer(input logic m, input logic [AW-1:0] b, input logic [CW-1:0] n,
                          input int lat, input int rdy_mode, input int inject);
    int reqs, pops, pop_done_cyc, done_cyc, minp, tot;
    logic done_exp, busy_exp;
    logic [NCH-1:0] rdy, hs;
    reqs = 0; pops = 0; done_cyc = -1;
    pop_done_cyc = (n == '0) ? 0 : -1;
    done_err = 0; busy_err = 0; credit_err = 0; timeout_err = 0; req_window = 0;
    first_rsp = -1; first_en = -1;
    addr_log.delete();
    for (int c = 0; c < NCH; c++) rx_n[c] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc == 0) begin
        start = 1'b1; mode = m; base_addr = b; num_words = n;
      end else if (cyc == inject) begin
        start = 1'b1; mode = ~m; base_addr = b + AW'(37); num_words = CW'(3);
      end else begin
        start = 1'b0;
      end
      done_exp = (pop_done_cyc >= 0) && (cyc == pop_done_cyc + 1);
      if (done !== done_exp) done_err++;
      busy_exp = (n != '0) && (cyc >= 1) && (done_cyc < 0) && !done_exp;
      if (busy !== busy_exp) busy_err++;
      if (done_exp) done_cyc = cyc;
      if (val_req_read === 1'b1) begin
        addr_log.push_back(val_addr_read);
        pend.push_back('{val_addr_read, cyc + lat});
        reqs++;
        if (cyc < 20) req_window++;
      end
      if (reqs - pops > int'(DEPTH)) credit_err++;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        val_enable_i = 1'b1;
        val_data_i   = glb_mem[pend[0].addr];
        void'(pend.pop_front());
        if (first_rsp < 0) first_rsp = cyc;
      end else begin
        val_enable_i = 1'b0;
        val_data_i   = DW'($urandom);
      end
      case (rdy_mode)
        1:       rdy = NCH'($urandom);
        2:       rdy = (cyc < 20) ? 4'b1011 : 4'b1111;
        3:       rdy = (cyc < 25) ? 4'b0000 : 4'b1111;
        default: rdy = '1;
      endcase
      val_ready_i = rdy;
      if ((|val_enable_o) && first_en < 0) first_en = cyc;
      hs = val_enable_o & rdy;
      for (int c = 0; c < NCH; c++) begin
        if (hs[c]) begin
          if (rx_n[c] < int'(MAXW)) rx[c][rx_n[c]] = val_data_o[c*DW +: DW];
          rx_n[c]++;
        end
      end
      minp = rx_n[0]; tot = 0;
      for (int c = 0; c < NCH; c++) begin
        tot += rx_n[c];
        if (rx_n[c] < minp) minp = rx_n[c];
      end
      pops = m ? tot : minp;
      if (pop_done_cyc < 0 && pops >= int'(n)) pop_done_cyc = cyc;
      tick();
      if (done_cyc >= 0 && cyc >= done_cyc + 1) break;
    end
    if (done_cyc < 0) timeout_err = 1;
    start = 1'b0;
    val_enable_i = 1'b0;
    val_ready_i = '1;
    pend.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    vectors++;
    if ({val_req_read, val_addr_read, val_enable_o, val_data_o, busy, done} !== '0) begin
      miscompares++; $display("FAIL reset_poweron: outputs=%h required 0",
        {val_req_read, val_addr_read, val_enable_o, val_data_o, busy, done});
    end
    reset = 1'b0;
    start = 1'b1; mode = 1'b0; base_addr = AW'(300); num_words = CW'(20);
    tick();
    start = 1'b0;
    repeat (4) tick();
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL reset_prefetch_busy: got %b required 1", busy); end
    reset = 1'b1;
    tick();
    vectors++;
    if ({val_req_read, val_addr_read, val_enable_o, val_data_o, busy, done} !== '0) begin
      miscompares++; $display("FAIL reset_midfetch: outputs=%h required 0",
        {val_req_read, val_addr_read, val_enable_o, val_data_o, busy, done});
    end
    repeat (2) tick();
    reset = 1'b0;
    tick();
    vectors++;
    if ({val_req_read, val_addr_read, val_enable_o, val_data_o, busy, done} !== '0) begin
      miscompares++; $display("FAIL reset_release: outputs=%h required 0",
        {val_req_read, val_addr_read, val_enable_o, val_data_o, busy, done});
    end
    build_model(1'b1, AW'(7), CW'(3));
    run_xfer(1'b1, AW'(7), CW'(3), 2, 0, -1);
    for (int c = 0; c < NCH; c++) begin
      vectors++;
      if (rx_n[c] !== exp_n[c]) begin miscompares++; $display("FAIL reset_fresh_count ch%0d: got %0d required %0d", c, rx_n[c], exp_n[c]); end
      for (int i = 0; i < exp_n[c] && i < rx_n[c]; i++) begin
        vectors++;
        if (rx[c][i] !== exp_rx[c][i]) begin miscompares++; $display("FAIL reset_fresh_data ch%0d[%0d]: got %h required %h", c, i, rx[c][i], exp_rx[c][i]); end
      end
    end
  endtask

  task automatic test_broadcast();
    build_model(1'b0, AW'(100), CW'(5));
    run_xfer(1'b0, AW'(100), CW'(5), 1, 0, -1);
    vectors++;
    if (addr_log.size() !== 5) begin miscompares++; $display("FAIL bcast_req_count: got %0d required 5", addr_log.size()); end
    for (int i = 0; i < 5 && i < addr_log.size(); i++) begin
      vectors++;
      if (addr_log[i] !== exp_addr[i]) begin miscompares++; $display("FAIL bcast_addr[%0d]: got %0d required %0d", i, addr_log[i], exp_addr[i]); end
    end
    for (int c = 0; c < NCH; c++) begin
      vectors++;
      if (rx_n[c] !== exp_n[c]) begin miscompares++; $display("FAIL bcast_count ch%0d: got %0d required %0d", c, rx_n[c], exp_n[c]); end
      for (int i = 0; i < exp_n[c] && i < rx_n[c]; i++) begin
        vectors++;
        if (rx[c][i] !== exp_rx[c][i]) begin miscompares++; $display("FAIL bcast_data ch%0d[%0d]: got %h required %h", c, i, rx[c][i], exp_rx[c][i]); end
      end
    end
    vectors++;
    if (first_en !== first_rsp + 1) begin miscompares++; $display("FAIL bcast_latency: first strobe cycle %0d required %0d", first_en, first_rsp + 1); end
    vectors++;
    if (done_err != 0 || busy_err != 0 || credit_err != 0 || timeout_err != 0) begin
      miscompares++; $display("FAIL bcast_protocol: done_err=%0d busy_err=%0d credit_err=%0d timeout=%0d required all 0", done_err, busy_err, credit_err, timeout_err);
    end
  endtask

  task automatic test_round_robin();
    logic [AW-1:0] b;
    for (int pass = 0; pass < 2; pass++) begin
      b = AW'($urandom);
      build_model(1'b1, b, CW'(6 + 5 * pass));
      run_xfer(1'b1, b, CW'(6 + 5 * pass), 1 + pass, pass, -1);
      for (int c = 0; c < NCH; c++) begin
        vectors++;
        if (rx_n[c] !== exp_n[c]) begin miscompares++; $display("FAIL rr_count p%0d ch%0d: got %0d required %0d", pass, c, rx_n[c], exp_n[c]); end
        for (int i = 0; i < exp_n[c] && i < rx_n[c]; i++) begin
          vectors++;
          if (rx[c][i] !== exp_rx[c][i]) begin miscompares++; $display("FAIL rr_data p%0d ch%0d[%0d]: got %h required %h", pass, c, i, rx[c][i], exp_rx[c][i]); end
        end
      end
      vectors++;
      if (done_err != 0 || busy_err != 0 || credit_err != 0 || timeout_err != 0) begin
        miscompares++; $display("FAIL rr_protocol p%0d: done_err=%0d busy_err=%0d credit_err=%0d timeout=%0d required all 0", pass, done_err, busy_err, credit_err, timeout_err);
      end
    end
  endtask

  task automatic test_backpressure();
    build_model(1'b0, AW'(200), CW'(16));
    run_xfer(1'b0, AW'(200), CW'(16), 1, 2, -1);
    vectors++;
    if (req_window !== int'(DEPTH)) begin miscompares++; $display("FAIL bp_credit_stall: got %0d requests required %0d", req_window, DEPTH); end
    for (int c = 0; c < NCH; c++) begin
      vectors++;
      if (rx_n[c] !== exp_n[c]) begin miscompares++; $display("FAIL bp_count ch%0d: got %0d required %0d", c, rx_n[c], exp_n[c]); end
      for (int i = 0; i < exp_n[c] && i < rx_n[c]; i++) begin
        vectors++;
        if (rx[c][i] !== exp_rx[c][i]) begin miscompares++; $display("FAIL bp_data ch%0d[%0d]: got %h required %h", c, i, rx[c][i], exp_rx[c][i]); end
      end
    end
    vectors++;
    if (done_err != 0 || busy_err != 0 || credit_err != 0 || timeout_err != 0) begin
      miscompares++; $display("FAIL bp_protocol: done_err=%0d busy_err=%0d credit_err=%0d timeout=%0d required all 0", done_err, busy_err, credit_err, timeout_err);
    end
  endtask

  task automatic test_boundaries();
    run_xfer(1'b0, AW'(5), CW'(0), 1, 0, -1);
    vectors++;
    if (addr_log.size() !== 0) begin miscompares++; $display("FAIL zero_words_reqs: got %0d required 0", addr_log.size()); end
    vectors++;
    if (done_err != 0 || busy_err != 0 || timeout_err != 0) begin
      miscompares++; $display("FAIL zero_words_done: done_err=%0d busy_err=%0d timeout=%0d required all 0", done_err, busy_err, timeout_err);
    end
    build_model(1'b0, AW'(1022), CW'(4));
    run_xfer(1'b0, AW'(1022), CW'(4), 1, 0, -1);
    vectors++;
    if (addr_log.size() !== 4) begin miscompares++; $display("FAIL wrap_req_count: got %0d required 4", addr_log.size()); end
    for (int i = 0; i < 4 && i < addr_log.size(); i++) begin
      vectors++;
      if (addr_log[i] !== exp_addr[i]) begin miscompares++; $display("FAIL wrap_addr[%0d]: got %0d required %0d", i, addr_log[i], exp_addr[i]); end
    end
    build_model(1'b0, AW'(50), CW'(12));
    run_xfer(1'b0, AW'(50), CW'(12), 1, 0, 3);
    vectors++;
    if (addr_log.size() !== 12) begin miscompares++; $display("FAIL ignore_start_reqs: got %0d required 12", addr_log.size()); end
    for (int c = 0; c < NCH; c++) begin
      vectors++;
      if (rx_n[c] !== exp_n[c]) begin miscompares++; $display("FAIL ignore_start_count ch%0d: got %0d required %0d", c, rx_n[c], exp_n[c]); end
      for (int i = 0; i < exp_n[c] && i < rx_n[c]; i++) begin
        vectors++;
        if (rx[c][i] !== exp_rx[c][i]) begin miscompares++; $display("FAIL ignore_start_data ch%0d[%0d]: got %h required %h", c, i, rx[c][i], exp_rx[c][i]); end
      end
    end
  endtask

  task automatic test_full_push_pop();
    build_model(1'b0, AW'(600), CW'(24));
    run_xfer(1'b0, AW'(600), CW'(24), 3, 3, -1);
    vectors++;
    if (req_window !== int'(DEPTH)) begin miscompares++; $display("FAIL full_stall: got %0d requests required %0d", req_window, DEPTH); end
    for (int c = 0; c < NCH; c++) begin
      vectors++;
      if (rx_n[c] !== exp_n[c]) begin miscompares++; $display("FAIL full_count ch%0d: got %0d required %0d", c, rx_n[c], exp_n[c]); end
      for (int i = 0; i < exp_n[c] && i < rx_n[c]; i++) begin
        vectors++;
        if (rx[c][i] !== exp_rx[c][i]) begin miscompares++; $display("FAIL full_data ch%0d[%0d]: got %h required %h", c, i, rx[c][i], exp_rx[c][i]); end
      end
    end
    vectors++;
    if (done_err != 0 || busy_err != 0 || credit_err != 0 || timeout_err != 0) begin
      miscompares++; $display("FAIL full_protocol: done_err=%0d busy_err=%0d credit_err=%0d timeout=%0d required all 0", done_err, busy_err, credit_err, timeout_err);
    end
  endtask

  task automatic test_random();
    logic          m;
    logic [AW-1:0] b;
    logic [CW-1:0] n;
    int            lat;
    for (int t = 0; t < 6; t++) begin
      m   = 1'($urandom);
      b   = AW'($urandom);
      n   = CW'($urandom_range(1, 40));
      lat = int'($urandom_range(1, 4));
      build_model(m, b, n);
      run_xfer(m, b, n, lat, 1, -1);
      vectors++;
      if (addr_log.size() !== int'(n)) begin miscompares++; $display("FAIL rand%0d_req_count: got %0d required %0d", t, addr_log.size(), n); end
      for (int i = 0; i < int'(n) && i < addr_log.size(); i++) begin
        vectors++;
        if (addr_log[i] !== exp_addr[i]) begin miscompares++; $display("FAIL rand%0d_addr[%0d]: got %0d required %0d", t, i, addr_log[i], exp_addr[i]); end
      end
      for (int c = 0; c < NCH; c++) begin
        vectors++;
        if (rx_n[c] !== exp_n[c]) begin miscompares++; $display("FAIL rand%0d_count ch%0d: got %0d required %0d", t, c, rx_n[c], exp_n[c]); end
        for (int i = 0; i < exp_n[c] && i < rx_n[c]; i++) begin
          vectors++;
          if (rx[c][i] !== exp_rx[c][i]) begin miscompares++; $display("FAIL rand%0d_data ch%0d[%0d]: got %h required %h", t, c, i, rx[c][i], exp_rx[c][i]); end
        end
      end
      vectors++;
      if (done_err != 0 || busy_err != 0 || credit_err != 0 || timeout_err != 0) begin
        miscompares++; $display("FAIL rand%0d_protocol: done_err=%0d busy_err=%0d credit_err=%0d timeout=%0d required all 0", t, done_err, busy_err, credit_err, timeout_err);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) glb_mem[i] = DW'($urandom);
    reset        = 1'b1;
    start        = 1'b0;
    mode         = 1'b0;
    base_addr    = '0;
    num_words    = '0;
    val_data_i   = '0;
    val_enable_i = 1'b0;
    val_ready_i  = '1;
    test_reset();
    test_broadcast();
    test_round_robin();
    test_backpressure();
    test_boundaries();
    test_full_push_pop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
